// File: rtl/att_pkg.sv
// Shared types and width defaults for the attention loop sequencer.
// The optional ATT_PERF_CNT_EN build adds performance counters in att_loop_seq.
package att_pkg;

   localparam int ATT_HNUM    = 4;
   localparam int ATT_VNUM    = 4;
   localparam int ATT_AW      = 10;
   localparam int ATT_SEQ_W   = 8;
   localparam int ATT_HEAD_W  = 4;
   localparam int ATT_MAX_OUT = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_DRAIN = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } ATT_SEQ_STATE;

   // Field widths follow the package defaults; the top's width parameters must match them.
   typedef struct packed {
      logic [ATT_SEQ_W-1:0]  seq_len;
      logic [ATT_HEAD_W-1:0] head_num;
      logic [ATT_AW-1:0]     rd_base;
      logic [ATT_AW-1:0]     wr_base;
      logic                  mode;
   } CFG_ATT_SEQ;

   function automatic logic cfgValid(input logic [ATT_SEQ_W-1:0]  seqLen,
                                     input logic [ATT_HEAD_W-1:0] headNum);
      return (seqLen != '0) && (headNum != '0);
   endfunction

endpackage

// File: rtl/att_loop_seq_if.sv
// Decoder/SRAM/GBUS-facing signal bundle of the attention loop sequencer.
// Perf counter outputs exist only when ATT_PERF_CNT_EN is defined.
interface att_loop_seq_if
   import att_pkg::*;
#(
   parameter int HNUM   = ATT_HNUM,
   parameter int VNUM   = ATT_VNUM,
   parameter int AW     = ATT_AW,
   parameter int SEQ_W  = ATT_SEQ_W,
   parameter int HEAD_W = ATT_HEAD_W
);
   logic                   start;
   logic                   abort;
   logic [SEQ_W-1:0]       cfg_seq_len;
   logic [HEAD_W-1:0]      cfg_head_num;
   logic [AW-1:0]          cfg_rd_base;
   logic [AW-1:0]          cfg_wr_base;
   logic                   cfg_mode;
   logic [HNUM*VNUM-1:0]   gbus_rvalid;
   logic [HNUM-1:0]        cons_ovalid;
   logic                   sram_ren;
   logic [AW-1:0]          sram_raddr;
   logic                   sram_wen;
   logic [AW-1:0]          sram_waddr;
   logic [HNUM-1:0]        hlink_wen;
   logic                   busy;
   logic                   done;
   logic                   cfg_err;
`ifdef ATT_PERF_CNT_EN
   logic [31:0]            perf_cycles;
   logic [31:0]            perf_stall;
`endif

   modport master (
      output start, abort, cfg_seq_len, cfg_head_num, cfg_rd_base, cfg_wr_base,
             cfg_mode, gbus_rvalid, cons_ovalid,
      input  sram_ren, sram_raddr, sram_wen, sram_waddr, hlink_wen, busy, done, cfg_err
`ifdef ATT_PERF_CNT_EN
      , input perf_cycles, perf_stall
`endif
   );

   modport slave (
      input  start, abort, cfg_seq_len, cfg_head_num, cfg_rd_base, cfg_wr_base,
             cfg_mode, gbus_rvalid, cons_ovalid,
      output sram_ren, sram_raddr, sram_wen, sram_waddr, hlink_wen, busy, done, cfg_err
`ifdef ATT_PERF_CNT_EN
      , output perf_cycles, perf_stall
`endif
   );

endinterface

// File: rtl/att_out_tracker.sv
// Outstanding-read counter: issue increments, an accepted return decrements,
// clear wins over both. Returns arriving with nothing outstanding are dropped.
module att_out_tracker #(
   parameter int MAX_OUT = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic i_issue,
   input  logic i_return,
   input  logic i_clear,
   output logic o_full,
   output logic o_empty
);
   localparam int CW = $clog2(MAX_OUT + 1);

   logic [CW-1:0] r_count;
   logic          w_retOk;

   assign w_retOk = i_return && (r_count != '0);
   assign o_full  = (r_count == CW'(MAX_OUT));
   assign o_empty = (r_count == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_issue && !w_retOk && !o_full) begin
         r_count <= r_count + CW'(1);
      end else if (!i_issue && w_retOk) begin
         r_count <= r_count - CW'(1);
      end
   end

endmodule

// File: rtl/att_loop_seq.sv
// Attention loop sequencer: walks heads x tokens, issues bounded reads, writes one word per head.
// Define ATT_PERF_CNT_EN to add the perf_cycles/perf_stall counters.
module att_loop_seq
   import att_pkg::*;
#(
   parameter int HNUM    = ATT_HNUM,
   parameter int VNUM    = ATT_VNUM,
   parameter int AW      = ATT_AW,
   parameter int SEQ_W   = ATT_SEQ_W,
   parameter int HEAD_W  = ATT_HEAD_W,
   parameter int MAX_OUT = ATT_MAX_OUT
) (
   input logic          clk,
   input logic          rstn,
   att_loop_seq_if.slave bus
);

   ATT_SEQ_STATE        r_state;
   CFG_ATT_SEQ          r_cfg;
   logic [SEQ_W-1:0]    r_issued;
   logic [HEAD_W-1:0]   r_head;
   logic [AW-1:0]       r_rdOfs;
   logic                r_ren;
   logic [AW-1:0]       r_raddr;
   logic                r_wen;
   logic [AW-1:0]       r_waddr;
   logic [HNUM-1:0]     r_hlink;
   logic                r_busy;
   logic                r_done;
   logic                r_cfgErr;

   logic [HNUM*VNUM-1:0] w_rvalid;
   logic [HNUM-1:0]      w_cons;
   logic                 w_rvAll;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_retOk;
   logic                 w_abort;
   logic                 w_startOk;
   logic                 w_canIssue;

   assign w_rvalid   = bus.gbus_rvalid;
   assign w_cons     = bus.cons_ovalid;
   assign w_rvAll    = &w_rvalid;
   assign w_retOk    = w_rvAll && !w_empty;
   assign w_abort    = bus.abort && (r_state != ST_IDLE);
   assign w_startOk  = (r_state == ST_IDLE) && bus.start
                       && cfgValid(bus.cfg_seq_len, bus.cfg_head_num);
   assign w_canIssue = (r_state == ST_ISSUE) && !w_full && !w_abort
                       && (r_issued != r_cfg.seq_len);

   att_out_tracker #(.MAX_OUT(MAX_OUT)) u_tracker (
      .clk      (clk),
      .rstn     (rstn),
      .i_issue  (w_canIssue),
      .i_return (w_rvAll),
      .i_clear  (w_abort),
      .o_full   (w_full),
      .o_empty  (w_empty)
   );

   // Read address is base plus a running offset so the pointer carries across heads.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= ST_IDLE;
         r_cfg    <= '0;
         r_issued <= '0;
         r_head   <= '0;
         r_rdOfs  <= '0;
         r_ren    <= 1'b0;
         r_raddr  <= '0;
         r_wen    <= 1'b0;
         r_waddr  <= '0;
         r_hlink  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_cfgErr <= 1'b0;
      end else begin
         r_ren   <= 1'b0;
         r_wen   <= 1'b0;
         r_done  <= 1'b0;
         r_hlink <= (w_retOk && r_cfg.mode) ? '1 : '0;
         if (w_abort) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_issued <= '0;
            r_head   <= '0;
            r_rdOfs  <= '0;
            r_hlink  <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_startOk) begin
                     r_cfg    <= '{seq_len:  bus.cfg_seq_len,
                                   head_num: bus.cfg_head_num,
                                   rd_base:  bus.cfg_rd_base,
                                   wr_base:  bus.cfg_wr_base,
                                   mode:     bus.cfg_mode};
                     r_cfgErr <= 1'b0;
                     r_state  <= ST_ISSUE;
                     r_busy   <= 1'b1;
                     r_issued <= '0;
                     r_head   <= '0;
                     r_rdOfs  <= '0;
                  end else if (bus.start) begin
                     r_cfgErr <= 1'b1;
                  end
               end
               ST_ISSUE: begin
                  if (w_canIssue) begin
                     r_ren    <= 1'b1;
                     r_raddr  <= r_cfg.rd_base + r_rdOfs;
                     r_rdOfs  <= r_rdOfs + AW'(1);
                     r_issued <= r_issued + SEQ_W'(1);
                     if ((r_issued + SEQ_W'(1)) == r_cfg.seq_len) begin
                        r_state <= ST_DRAIN;
                     end
                  end
               end
               ST_DRAIN: begin
                  if (w_empty && (&w_cons)) begin
                     r_state <= ST_WRITE;
                     r_wen   <= 1'b1;
                     r_waddr <= r_cfg.wr_base + AW'(r_head);
                  end
               end
               ST_WRITE: begin
                  r_head <= r_head + HEAD_W'(1);
                  if ((r_head + HEAD_W'(1)) == r_cfg.head_num) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state  <= ST_ISSUE;
                     r_issued <= '0;
                  end
               end
               ST_DONE: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.sram_ren   = r_ren;
   assign bus.sram_raddr = r_raddr;
   assign bus.sram_wen   = r_wen;
   assign bus.sram_waddr = r_waddr;
   assign bus.hlink_wen  = r_hlink;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.cfg_err    = r_cfgErr;

`ifdef ATT_PERF_CNT_EN
   logic [31:0] r_perfCycles;
   logic [31:0] r_perfStall;

   // Counters restart on an accepted start and simply stop moving once back in IDLE.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_perfCycles <= '0;
         r_perfStall  <= '0;
      end else if (w_startOk) begin
         r_perfCycles <= '0;
         r_perfStall  <= '0;
      end else begin
         if ((r_state != ST_IDLE) && (r_perfCycles != '1)) begin
            r_perfCycles <= r_perfCycles + 32'd1;
         end
         if ((r_state == ST_ISSUE) && w_full && (r_perfStall != '1)) begin
            r_perfStall <= r_perfStall + 32'd1;
         end
      end
   end

   assign bus.perf_cycles = r_perfCycles;
   assign bus.perf_stall  = r_perfStall;
`endif

endmodule

// File: tb/tb_att_loop_seq.sv
// Self-checking bench for att_loop_seq: directed runs against an address-queue model.
module tb_att_loop_seq;

   localparam int HNUM    = 4;
   localparam int VNUM    = 4;
   localparam int AW      = 10;
   localparam int MAX_OUT = 4;

   logic clk;
   logic rstn;

   att_loop_seq_if bus ();

   att_loop_seq #(.MAX_OUT(MAX_OUT)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [AW-1:0]   expRd[$];
   logic [AW-1:0]   expWr[$];
   logic [AW-1:0]   obsRd[$];
   logic [AW-1:0]   obsWr[$];
   int              outst    = 0;
   int              renCnt   = 0;
   int              wenCnt   = 0;
   int              hlinkCnt = 0;
   int              doneCnt  = 0;
   int              renBase, wenBase, hlinkBase, doneBase;
   logic            modelMode = 1'b0;
   logic [HNUM-1:0] expHlink  = '0;
   bit              monEn     = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Model: every read is base+k (mod 2^AW), every write is wr_base+h; returns count only
   // when all channels are valid and something is outstanding; PV mirrors each into hlink.
   always @(negedge clk) begin
      if (monEn) begin
         checkOutput("hlink_wen", 32'(bus.hlink_wen), 32'(expHlink));
         if (bus.hlink_wen != '0) hlinkCnt++;
         expHlink = '0;
         if (bus.sram_ren) begin
            renCnt++;
            outst++;
            obsRd.push_back(bus.sram_raddr);
            if (expRd.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_ren: got raddr 0x%0h, required no read", bus.sram_raddr);
            end else begin
               checkOutput("sram_raddr", 32'(bus.sram_raddr), 32'(expRd.pop_front()));
            end
            checkOutput("outstanding_limit", (outst <= MAX_OUT) ? 32'd1 : 32'd0, 32'd1);
         end
         if (bus.sram_wen) begin
            wenCnt++;
            obsWr.push_back(bus.sram_waddr);
            if (expWr.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_wen: got waddr 0x%0h, required no write", bus.sram_waddr);
            end else begin
               checkOutput("sram_waddr", 32'(bus.sram_waddr), 32'(expWr.pop_front()));
            end
         end
         if (bus.done) doneCnt++;
         if ((&bus.gbus_rvalid) && (outst > 0)) begin
            outst--;
            if (modelMode) expHlink = '1;
         end
      end
   end

   task automatic applyStimulus(input int seqLen, input int headNum,
                                input logic [AW-1:0] rdBase, input logic [AW-1:0] wrBase,
                                input logic mode);
      for (int k = 0; k < seqLen * headNum; k++) expRd.push_back(rdBase + AW'(k));
      for (int h = 0; h < headNum; h++) expWr.push_back(wrBase + AW'(h));
      obsRd.delete();
      obsWr.delete();
      renBase   = renCnt;
      wenBase   = wenCnt;
      hlinkBase = hlinkCnt;
      doneBase  = doneCnt;
      modelMode = mode;
      bus.cfg_seq_len  = 8'(seqLen);
      bus.cfg_head_num = 4'(headNum);
      bus.cfg_rd_base  = rdBase;
      bus.cfg_wr_base  = wrBase;
      bus.cfg_mode     = mode;
      bus.start = 1'b1;
      stepCycle();
      bus.start = 1'b0;
      bus.cfg_seq_len  = 8'hA5;
      bus.cfg_head_num = 4'hF;
      bus.cfg_rd_base  = ~rdBase;
      bus.cfg_wr_base  = ~wrBase;
      bus.cfg_mode     = ~mode;
   endtask

   task automatic waitDone(input int budget, input string name, output int n);
      n = 0;
      do begin
         stepCycle();
         n++;
      end while (!bus.done && n < budget);
      checkOutput(name, 32'(bus.done), 32'd1);
   endtask

   task automatic finishRun(input int expRen, input int expWen, input int expHl);
      checkOutput("busy_in_done", 32'(bus.busy), 32'd1);
      stepCycle();
      checkOutput("done_one_cycle", 32'(bus.done), 32'd0);
      checkOutput("busy_after_done", 32'(bus.busy), 32'd0);
      checkOutput("ren_count", 32'(renCnt - renBase), 32'(expRen));
      checkOutput("wen_count", 32'(wenCnt - wenBase), 32'(expWen));
      checkOutput("hlink_count", 32'(hlinkCnt - hlinkBase), 32'(expHl));
      checkOutput("done_count", 32'(doneCnt - doneBase), 32'd1);
      checkOutput("reads_pending", 32'(expRd.size()), 32'd0);
      checkOutput("writes_pending", 32'(expWr.size()), 32'd0);
      stepCycle();
   endtask

   initial begin
      int n;
      rstn = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.cfg_seq_len  = '0;
      bus.cfg_head_num = '0;
      bus.cfg_rd_base  = '0;
      bus.cfg_wr_base  = '0;
      bus.cfg_mode     = 1'b0;
      bus.gbus_rvalid  = '1;
      bus.cons_ovalid  = '1;
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", 32'(bus.busy), 32'd0);
      checkOutput("reset_done", 32'(bus.done), 32'd0);
      checkOutput("reset_ren", 32'(bus.sram_ren), 32'd0);
      checkOutput("reset_wen", 32'(bus.sram_wen), 32'd0);
      checkOutput("reset_cfg_err", 32'(bus.cfg_err), 32'd0);
      checkOutput("reset_hlink", 32'(bus.hlink_wen), 32'd0);
      checkOutput("reset_raddr", 32'(bus.sram_raddr), 32'd0);
      stepCycle();
      rstn  = 1'b1;
      monEn = 1'b1;
      stepCycle();

      // QK, two heads, config scrambled after start
      applyStimulus(4, 2, 10'h010, 10'h080, 1'b0);
      checkOutput("busy_after_start", 32'(bus.busy), 32'd1);
      waitDone(100, "run1_done", n);
      finishRun(8, 2, 0);
      checkOutput("run1_rd_first", 32'(obsRd[0]), 32'h010);
      checkOutput("run1_rd_last", 32'(obsRd[7]), 32'h017);
      checkOutput("run1_wr0", 32'(obsWr[0]), 32'h080);
      checkOutput("run1_wr1", 32'(obsWr[1]), 32'h081);

      // Outstanding limit with returns withheld; a start while busy must be ignored
      bus.gbus_rvalid = '0;
      applyStimulus(8, 1, 10'h020, 10'h060, 1'b0);
      repeat (5) stepCycle();
      bus.cfg_seq_len = 8'd1;
      bus.cfg_head_num = 4'd1;
      bus.cfg_rd_base = 10'h100;
      bus.start = 1'b1;
      stepCycle();
      bus.start = 1'b0;
      repeat (6) stepCycle();
      checkOutput("ren_before_release", 32'(renCnt - renBase), 32'd4);
      checkOutput("busy_while_stalled", 32'(bus.busy), 32'd1);
      checkOutput("cfg_err_busy_start", 32'(bus.cfg_err), 32'd0);
      bus.gbus_rvalid = '1;
      waitDone(100, "run2_done", n);
      finishRun(8, 1, 0);

      // PV with one channel lagging for two cycles
      applyStimulus(3, 1, 10'h030, 10'h070, 1'b1);
      stepCycle();
      bus.gbus_rvalid = 16'hFFDF;
      repeat (2) stepCycle();
      bus.gbus_rvalid = '1;
      waitDone(100, "run3_done", n);
      finishRun(3, 1, 3);

      // Address wrap on both read and write sides
      applyStimulus(4, 2, 10'h3FE, 10'h3FF, 1'b0);
      waitDone(100, "run4_done", n);
      finishRun(8, 2, 0);
      checkOutput("wrap_rd0", 32'(obsRd[0]), 32'h3FE);
      checkOutput("wrap_rd1", 32'(obsRd[1]), 32'h3FF);
      checkOutput("wrap_rd2", 32'(obsRd[2]), 32'h000);
      checkOutput("wrap_rd3", 32'(obsRd[3]), 32'h001);
      checkOutput("wrap_wr1", 32'(obsWr[1]), 32'h000);

      // Abort while parked in DRAIN, then a fresh PV run
      bus.cons_ovalid = '0;
      applyStimulus(2, 1, 10'h050, 10'h0A0, 1'b0);
      repeat (8) stepCycle();
      checkOutput("busy_in_drain", 32'(bus.busy), 32'd1);
      checkOutput("abort_reads_done", 32'(renCnt - renBase), 32'd2);
      expWr.delete();
      bus.abort = 1'b1;
      stepCycle();
      bus.abort = 1'b0;
      checkOutput("busy_after_abort", 32'(bus.busy), 32'd0);
      bus.cons_ovalid = '1;
      repeat (5) stepCycle();
      checkOutput("abort_no_done", 32'(doneCnt - doneBase), 32'd0);
      checkOutput("abort_no_wen", 32'(wenCnt - wenBase), 32'd0);
      applyStimulus(3, 1, 10'h040, 10'h090, 1'b1);
      waitDone(100, "run5_done", n);
      finishRun(3, 1, 3);

      // Config errors: zero length, then zero heads, each cleared by a valid start
      bus.cfg_seq_len = 8'd0;
      bus.cfg_head_num = 4'd2;
      bus.start = 1'b1;
      stepCycle();
      bus.start = 1'b0;
      checkOutput("cfg_err_zero_len", 32'(bus.cfg_err), 32'd1);
      repeat (3) stepCycle();
      checkOutput("busy_on_cfg_err", 32'(bus.busy), 32'd0);
      applyStimulus(2, 1, 10'h008, 10'h020, 1'b0);
      checkOutput("cfg_err_cleared", 32'(bus.cfg_err), 32'd0);
      waitDone(100, "run6_done", n);
      finishRun(2, 1, 0);
      bus.cfg_seq_len = 8'd3;
      bus.cfg_head_num = 4'd0;
      bus.start = 1'b1;
      stepCycle();
      bus.start = 1'b0;
      checkOutput("cfg_err_zero_head", 32'(bus.cfg_err), 32'd1);
      checkOutput("busy_on_zero_head", 32'(bus.busy), 32'd0);

      // Minimum latency run
      applyStimulus(1, 1, 10'h003, 10'h004, 1'b0);
      checkOutput("cfg_err_cleared2", 32'(bus.cfg_err), 32'd0);
      waitDone(20, "run7_done", n);
      checkOutput("start_to_done_latency", 32'(1 + n), 32'd5);
      finishRun(1, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
